// File: rtl/pipe_cmd_issuer_pkg.sv
// Shared definitions for the pipeline command issuer: field widths,
// bubble opcode, issuer FSM states and the packed command record.
package pipe_cmd_pkg;

    localparam int REG_W  = 5;
    localparam int FUNC_W = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Opcode the processor treats as a no-op; driven on bubble cycles.
    localparam logic [FUNC_W-1:0] NOP_FUNC_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One host command as queued and issued (51 bits).
    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/pipe_cmd_issuer_fifo.sv
// Command FIFO: DEPTH entries of cmd_t with registered full/empty flags.
// Read data is the head entry, valid whenever empty is low.
module cmd_fifo
    import pipe_cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  cmd_t wr_data,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Post-update occupancy; flags are registered from this value.
    always_comb begin
        count_nxt = count;
        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pipe_cmd_issuer.sv
// Initiator side of the processor command interface: queues host commands,
// issues one per clock (or a bubble), and tags each issue through a
// LATENCY-deep pipe so the matching mem_out can be captured on retirement.
module pipe_cmd_issuer
    import pipe_cmd_pkg::*;
#(
    parameter int                DEPTH    = 8,
    parameter int                LATENCY  = 4,
    parameter logic [FUNC_W-1:0] NOP_FUNC = NOP_FUNC_DEFAULT,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rs2,
    output logic [REG_W-1:0]  rd,
    output logic [FUNC_W-1:0] func,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_out,
    output logic              res_valid,
    output logic [REG_W-1:0]  res_rd,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] addr;
    } tag_t;

    state_t state;
    state_t state_nxt;
    cmd_t   in_cmd;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   tag_busy;
    tag_t   tag_pipe [LATENCY];

    assign in_cmd   = {in_rs1, in_rs2, in_rd, in_func, in_addr};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || !fifo_empty;

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_cmd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Any command still travelling through the processor pipeline.
    always_comb begin
        tag_busy = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_busy = tag_busy | tag_pipe[i].v;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and pop decision; dropping go in RUN suppresses that cycle's pop.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) state_nxt = RUN;
            end
            RUN: begin
                if (!go) state_nxt = DRAIN;
                else     pop       = !fifo_empty;
            end
            DRAIN: begin
                if (go)             state_nxt = RUN;
                else if (!tag_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue register: popped command, or a bubble that keeps addr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1  <= '0;
            rs2  <= '0;
            rd   <= '0;
            func <= NOP_FUNC;
            addr <= '0;
        end else if (pop) begin
            rs1  <= head.rs1;
            rs2  <= head.rs2;
            rd   <= head.rd;
            func <= head.func;
            addr <= head.addr;
        end else begin
            rs1  <= '0;
            rs2  <= '0;
            rd   <= '0;
            func <= NOP_FUNC;
        end
    end

    // Tag pipe: one stage per processor pipeline cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{v: pop, rd: head.rd, addr: head.addr};
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Result capture when the oldest tag reaches the end of the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_addr  <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_pipe[LATENCY-1].v;
            if (tag_pipe[LATENCY-1].v) begin
                res_rd   <= tag_pipe[LATENCY-1].rd;
                res_addr <= tag_pipe[LATENCY-1].addr;
                res_data <= mem_out;
            end
        end
    end

    // Wrapping issue/retire counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt  <= '0;
            retired_cnt <= '0;
        end else begin
            if (pop)                    issued_cnt  <= issued_cnt + CNT_W'(1);
            if (tag_pipe[LATENCY-1].v)  retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule
